acq_peak_search: RTL and testbench

- Sequencer in the acquire engine that scans the correlation amplitude buffer after a search pass. It reports the global peak amplitude, its bin index and the summed amplitude used for the noise floor.
- Each buffer word holds four 9-bit amplitudes. The block streams the words one per cycle through the four-input max/index comparator (amp_compare) and keeps a running best result.
- Sits between the acquisition control FSM (start/done) and the amplitude buffer read port.

---
 rtl/acq_peak_search.sv | 161 ++++++++++++++++
 tb/tb_acq_peak_search.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/acq_peak_search.sv
// Acquire-engine peak search: streams 4-lane amplitude words, tracks peak, peak index and saturating sum.
// Optional second-peak tracking is enabled by defining PEAK_SEARCH_SECOND_PEAK_EN.

module acq_peak_search #(
    parameter int unsigned ADDR_WIDTH = 7,
    parameter int unsigned SUM_WIDTH  = 18
) (
    input  logic                  clk,
    input  logic                  rst_b,
    input  logic                  start,
    input  logic                  abort,
    input  logic [ADDR_WIDTH:0]   word_count,
    output logic                  mem_rd,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [35:0]           mem_rdata,
    output logic                  busy,
    output logic                  done,
    output logic [8:0]            peak_amp,
    output logic [ADDR_WIDTH+1:0] peak_index,
    output logic [SUM_WIDTH-1:0]  amp_sum
`ifdef PEAK_SEARCH_SECOND_PEAK_EN
    ,
    output logic [8:0]            second_amp,
    output logic [ADDR_WIDTH+1:0] second_index
`endif
);

    localparam int unsigned AMP_W     = 9;
    localparam int unsigned LANES     = 4;
    localparam int unsigned WC_W      = ADDR_WIDTH + 1;
    localparam int unsigned IDX_W     = ADDR_WIDTH + 2;
    localparam int unsigned WSUM_W    = AMP_W + 2;
    localparam int unsigned SUM_EXT_W = SUM_WIDTH + 1;

    localparam logic [WC_W-1:0] WC_MAX = {1'b1, {ADDR_WIDTH{1'b0}}};

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_READ   = 2'd1;
    localparam logic [1:0] S_DRAIN  = 2'd2;
    localparam logic [1:0] S_FINISH = 2'd3;

    logic [1:0]            state;
    logic [1:0]            state_next;
    logic [ADDR_WIDTH-1:0] last_addr;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  rd_vld;

    logic                  accept_c;
    logic                  consume_c;
    logic [WC_W-1:0]       wc_clamp_c;
    logic [ADDR_WIDTH-1:0] last_c;
    logic [AMP_W-1:0]      word_max_c;
    logic [1:0]            word_lane_c;
    logic [WSUM_W-1:0]     word_sum_c;
    logic [IDX_W-1:0]      word_index_c;
    logic [SUM_EXT_W-1:0]  sum_ext_c;
    logic [SUM_WIDTH-1:0]  sum_next_c;

    always_comb begin
        wc_clamp_c = (word_count > WC_MAX) ? WC_MAX : word_count;
        last_c     = ADDR_WIDTH'(wc_clamp_c - WC_W'(1));
        accept_c   = (state == S_IDLE) && start;
        consume_c  = rd_vld && !abort;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:   if (start) state_next = (word_count == '0) ? S_FINISH : S_READ;
            S_READ: begin
                if (abort)                       state_next = S_IDLE;
                else if (mem_addr == last_addr)  state_next = S_DRAIN;
            end
            S_DRAIN:  state_next = abort ? S_IDLE : S_FINISH;
            S_FINISH: state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    // amp_compare: word max with lowest-lane tie break, plus lane sum
    always_comb begin
        logic [AMP_W-1:0] amp;
        amp         = '0;
        word_max_c  = '0;
        word_lane_c = '0;
        word_sum_c  = '0;
        for (int i = 0; i < int'(LANES); i++) begin
            amp        = mem_rdata[i*AMP_W +: AMP_W];
            word_sum_c = word_sum_c + WSUM_W'(amp);
            if (amp > word_max_c) begin
                word_max_c  = amp;
                word_lane_c = 2'(i);
            end
        end
        word_index_c = {rd_addr, word_lane_c};
        sum_ext_c    = {1'b0, amp_sum} + SUM_EXT_W'(word_sum_c);
        sum_next_c   = sum_ext_c[SUM_WIDTH] ? '1 : sum_ext_c[SUM_WIDTH-1:0];
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            mem_rd    <= 1'b0;
            done      <= 1'b0;
            mem_addr  <= '0;
            last_addr <= '0;
            rd_vld    <= 1'b0;
            rd_addr   <= '0;
        end else begin
            state   <= state_next;
            busy    <= (state_next != S_IDLE);
            mem_rd  <= (state_next == S_READ);
            done    <= (state_next == S_FINISH);
            // data returning after an abort is dropped here
            rd_vld  <= mem_rd && !abort;
            rd_addr <= mem_addr;
            if (accept_c) begin
                mem_addr  <= '0;
                last_addr <= last_c;
            end else if ((state == S_READ) && (state_next == S_READ)) begin
                mem_addr <= mem_addr + ADDR_WIDTH'(1);
            end
        end
    end

    // Running results; strict compare keeps the earliest index on ties
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            peak_amp     <= '0;
            peak_index   <= '0;
            amp_sum      <= '0;
`ifdef PEAK_SEARCH_SECOND_PEAK_EN
            second_amp   <= '0;
            second_index <= '0;
`endif
        end else if (accept_c) begin
            peak_amp     <= '0;
            peak_index   <= '0;
            amp_sum      <= '0;
`ifdef PEAK_SEARCH_SECOND_PEAK_EN
            second_amp   <= '0;
            second_index <= '0;
`endif
        end else if (consume_c) begin
            amp_sum <= sum_next_c;
            if (word_max_c > peak_amp) begin
                peak_amp   <= word_max_c;
                peak_index <= word_index_c;
`ifdef PEAK_SEARCH_SECOND_PEAK_EN
                second_amp   <= peak_amp;
                second_index <= peak_index;
            end else if (word_max_c > second_amp) begin
                second_amp   <= word_max_c;
                second_index <= word_index_c;
`endif
            end
        end
    end

endmodule

// File: tb/tb_acq_peak_search.sv
// Self-checking bench for acq_peak_search: directed table, abort/reset sequences, randomized scans vs model.

module tb_acq_peak_search;

    localparam int AW   = 7;
    localparam int SW   = 16;
    localparam int NW   = 1 << AW;
    localparam int SMAX = (1 << SW) - 1;

    logic          clk = 1'b0;
    logic          rst_b = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [AW:0]   word_count = '0;
    logic          mem_rd;
    logic [AW-1:0] mem_addr;
    logic [35:0]   mem_rdata = '0;
    logic          busy;
    logic          done;
    logic [8:0]    peak_amp;
    logic [AW+1:0] peak_index;
    logic [SW-1:0] amp_sum;
`ifdef PEAK_SEARCH_SECOND_PEAK_EN
    logic [8:0]    second_amp;
    logic [AW+1:0] second_index;
`endif

    typedef struct {
        int wc;
        int mode;
        int peak;
        int idx;
        int sum;
        int second;
        int sidx;
    } vec_t;

    logic [35:0] mem [NW];
    int n_checks = 0;
    int n_fail   = 0;
    vec_t vecs [6];

    acq_peak_search #(.ADDR_WIDTH(AW), .SUM_WIDTH(SW)) dut (
        .clk        (clk),
        .rst_b      (rst_b),
        .start      (start),
        .abort      (abort),
        .word_count (word_count),
        .mem_rd     (mem_rd),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .busy       (busy),
        .done       (done),
        .peak_amp   (peak_amp),
        .peak_index (peak_index),
        .amp_sum    (amp_sum)
`ifdef PEAK_SEARCH_SECOND_PEAK_EN
        ,
        .second_amp   (second_amp),
        .second_index (second_index)
`endif
    );

    always #5 clk = ~clk;

    // Buffer read port: one-cycle latency, garbage when not read
    always @(posedge clk) begin
        if (mem_rd) mem_rdata <= mem[mem_addr];
        else        mem_rdata <= 36'({$urandom(), $urandom()});
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [35:0] pack4(input int a, input int b, input int c, input int d);
        return {9'(d), 9'(c), 9'(b), 9'(a)};
    endfunction

    function automatic logic [35:0] rand_word(input int maxv);
        return pack4($urandom_range(0, maxv), $urandom_range(0, maxv),
                     $urandom_range(0, maxv), $urandom_range(0, maxv));
    endfunction

    task automatic fill(input int mode);
        for (int w = 0; w < NW; w++) begin
            case (mode)
                0: mem[w] = (w == 0) ? pack4(1, 2, 3, 4) : (w == 1) ? pack4(10, 9, 8, 7) :
                            (w == 2) ? pack4(0, 0, 0, 0) : (w == 3) ? pack4(5, 5, 5, 5) : rand_word(511);
                1: mem[w] = pack4(300, 300, 300, 300);
                2: mem[w] = pack4(511, 511, 511, 511);
                4: mem[w] = (w == 0) ? pack4(50, 1, 2, 3) : (w == 1) ? pack4(80, 1, 2, 3) :
                            (w == 2) ? pack4(60, 1, 2, 3) : rand_word(511);
                5: mem[w] = rand_word(3);
                default: mem[w] = rand_word(511);
            endcase
        end
    endtask

    // Reference: flat scan over lanes in index order; second peak = best of the other words
    task automatic model(input int wc, output vec_t e);
        int n, a, total, pw;
        n = (wc > NW) ? NW : wc;
        e.wc = wc; e.mode = 0;
        e.peak = 0; e.idx = 0; total = 0;
        for (int w = 0; w < n; w++)
            for (int l = 0; l < 4; l++) begin
                a = int'(mem[w][l*9 +: 9]);
                total += a;
                if (a > e.peak) begin e.peak = a; e.idx = w * 4 + l; end
            end
        e.sum = (total > SMAX) ? SMAX : total;
        pw = e.idx / 4;
        e.second = 0; e.sidx = 0;
        for (int w = 0; w < n; w++)
            if (w != pw)
                for (int l = 0; l < 4; l++) begin
                    a = int'(mem[w][l*9 +: 9]);
                    if (a > e.second) begin e.second = a; e.sidx = w * 4 + l; end
                end
    endtask

    // Called at a negedge; start is sampled at the following posedge (cycle 0)
    task automatic run_scan(input string tag, input int wc, input vec_t e);
        int n, exp_dc, dc, rd, bz;
        bit seen;
        n = (wc > NW) ? NW : wc;
        exp_dc = (n == 0) ? 1 : n + 2;
        word_count = wc[AW:0];
        start = 1'b1;
        seen = 1'b0; dc = 0; rd = 0; bz = 0;
        for (int c = 1; c <= NW + 10 && !seen; c++) begin
            @(negedge clk);
            if (c == 1) start = 1'b0;
            if (mem_rd) rd++;
            if (busy) bz++;
            if (c == 2 && n >= 2) begin start = 1'b1; word_count = 8'($urandom_range(1, 20)); end
            if (c == 3) start = 1'b0;
            if (done) begin
                seen = 1'b1;
                dc = c;
                start = 1'b1;
                word_count = 8'd5;
            end
        end
        check({tag, "_done_cycle"}, 64'(dc), 64'(exp_dc));
        check({tag, "_rd_cycles"}, 64'(rd), 64'(n));
        check({tag, "_busy_cycles"}, 64'(bz), 64'(exp_dc));
        check({tag, "_peak_amp"}, 64'(peak_amp), 64'(e.peak));
        check({tag, "_peak_index"}, 64'(peak_index), 64'(e.idx));
        check({tag, "_amp_sum"}, 64'(amp_sum), 64'(e.sum));
`ifdef PEAK_SEARCH_SECOND_PEAK_EN
        check({tag, "_second_amp"}, 64'(second_amp), 64'(e.second));
        check({tag, "_second_index"}, 64'(second_index), 64'(e.sidx));
`endif
        @(negedge clk);
        start = 1'b0;
        check({tag, "_done_pulse"}, 64'(done), 64'(0));
        check({tag, "_start_in_finish_ignored"}, 64'(busy), 64'(0));
        check({tag, "_peak_hold"}, 64'(peak_amp), 64'(e.peak));
        check({tag, "_sum_hold"}, 64'(amp_sum), 64'(e.sum));
    endtask

    initial begin
        vec_t e;
        int wc;

        vecs[0] = '{4,   0, 10,  4, 64,    5,   12};
        vecs[1] = '{3,   1, 300, 0, 3600,  300, 4};
        vecs[2] = '{128, 2, 511, 0, 65535, 511, 4};
        vecs[3] = '{0,   3, 0,   0, 0,     0,   0};
        vecs[4] = '{200, 2, 511, 0, 65535, 511, 4};
        vecs[5] = '{3,   4, 80,  4, 208,   60,  8};

        repeat (3) @(negedge clk);
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_mem_rd", 64'(mem_rd), 64'(0));
        check("rst_mem_addr", 64'(mem_addr), 64'(0));
        check("rst_peak_amp", 64'(peak_amp), 64'(0));
        check("rst_peak_index", 64'(peak_index), 64'(0));
        check("rst_amp_sum", 64'(amp_sum), 64'(0));
        rst_b = 1'b1;
        @(negedge clk);
        check("post_rst_busy", 64'(busy), 64'(0));

        for (int i = 0; i < 6; i++) begin
            fill(vecs[i].mode);
            run_scan($sformatf("vec%0d", i), vecs[i].wc, vecs[i]);
            @(negedge clk);
        end

        // abort during cycle 3 of a 10-word scan, restart at cycle 5
        fill(6);
        word_count = 8'd10;
        start = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            if (c == 1) start = 1'b0;
            if (c == 3) begin
                check("abort_busy_before", 64'(busy), 64'(1));
                abort = 1'b1;
            end
            if (c == 4) begin
                abort = 1'b0;
                check("abort_busy_drop", 64'(busy), 64'(0));
                check("abort_mem_rd_drop", 64'(mem_rd), 64'(0));
                check("abort_no_done", 64'(done), 64'(0));
            end
        end
        @(negedge clk);
        model(10, e);
        run_scan("after_abort", 10, e);
        @(negedge clk);

        // asynchronous reset in the middle of a scan
        fill(6);
        word_count = 8'd50;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        rst_b = 1'b0;
        #1;
        check("midrst_busy", 64'(busy), 64'(0));
        check("midrst_mem_rd", 64'(mem_rd), 64'(0));
        check("midrst_mem_addr", 64'(mem_addr), 64'(0));
        check("midrst_peak_amp", 64'(peak_amp), 64'(0));
        check("midrst_amp_sum", 64'(amp_sum), 64'(0));
        @(negedge clk);
        rst_b = 1'b1;
        @(negedge clk);
        model(7, e);
        run_scan("after_rst", 7, e);
        @(negedge clk);

        for (int i = 0; i < 20; i++) begin
            fill(($urandom_range(0, 1) == 0) ? 5 : 6);
            wc = ($urandom_range(0, 7) == 0) ? $urandom_range(129, 255) : $urandom_range(0, 40);
            model(wc, e);
            run_scan($sformatf("rand%0d_wc%0d", i, wc), wc, e);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
